// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and defaults for the memory arbiter slice.
//   state_t  : arbiter sequencer states (IDLE, ACCESS, RESP)
//   grant_t  : which requester owns the memory (GRANT_INSTR / GRANT_DATA)
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default bus widths
// ----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin picker.
//   req[1:0]   : in  request vector, bit 0 = instruction, bit 1 = data
//   last_grant : in  requester served most recently
//   gnt_valid  : out at least one request present
//   gnt_id     : out chosen requester
// ----------------------------------------------------------------------------
module rr_arbiter2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic       gnt_valid,
    output grant_t     gnt_id
);

    // On contention the requester that was not served last wins; otherwise
    // the single active requester is taken as-is.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = GRANT_INSTR;
        if (req == 2'b11) begin
            gnt_id = (last_grant == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
        end else if (req[1]) begin
            gnt_id = GRANT_DATA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
// Shares one single-port memory between the instruction-fetch port and the
// data port of the core. Each access takes IDLE -> ACCESS -> RESP and ends
// with a one-cycle ack on the owning port.
//   clk_i, rst_i                        : clock, async active-low reset
//   ireq_i, iaddr_i, iack_o, idata_o    : instruction read port
//   dreq_i, dwe_i, daddr_i, dwdata_i,
//   dack_o, drdata_o                    : data read/write port
//   mem_cs_o, mem_we_o, mem_addr_o,
//   mem_data_o, mem_data_i              : memory interface
// ----------------------------------------------------------------------------
module memory_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ireq_i,
    input  logic [ADDR_W-1:0] iaddr_i,
    output logic              iack_o,
    output logic [DATA_W-1:0] idata_o,
    input  logic              dreq_i,
    input  logic              dwe_i,
    input  logic [ADDR_W-1:0] daddr_i,
    input  logic [DATA_W-1:0] dwdata_i,
    output logic              dack_o,
    output logic [DATA_W-1:0] drdata_o,
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    logic   w_gntValid;
    grant_t w_gntId;

    state_t r_state;
    grant_t r_grant;
    grant_t r_lastGrant;
    logic   r_isWrite;

    rr_arbiter2 u_rrArbiter (
        .req        ({dreq_i, ireq_i}),
        .last_grant (r_lastGrant),
        .gnt_valid  (w_gntValid),
        .gnt_id     (w_gntId)
    );

    // Access sequencer. Memory outputs are latched when the access is granted
    // so the requester's inputs are no longer needed afterwards; this is why
    // a request dropped early still completes. last_grant resets to DATA so
    // the instruction port wins the first contention.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_grant     <= GRANT_INSTR;
            r_lastGrant <= GRANT_DATA;
            r_isWrite   <= 1'b0;
            mem_cs_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            iack_o      <= 1'b0;
            dack_o      <= 1'b0;
            idata_o     <= '0;
            drdata_o    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    iack_o <= 1'b0;
                    dack_o <= 1'b0;
                    if (w_gntValid) begin
                        r_grant  <= w_gntId;
                        mem_cs_o <= 1'b1;
                        if (w_gntId == GRANT_DATA) begin
                            mem_we_o   <= dwe_i;
                            mem_addr_o <= daddr_i;
                            mem_data_o <= dwdata_i;
                            r_isWrite  <= dwe_i;
                        end else begin
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= iaddr_i;
                            r_isWrite  <= 1'b0;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_cs_o <= 1'b0;
                    mem_we_o <= 1'b0;
                    r_state  <= RESP;
                end
                RESP: begin
                    if (r_grant == GRANT_DATA) begin
                        dack_o <= 1'b1;
                        if (!r_isWrite) begin
                            drdata_o <= mem_data_i;
                        end
                    end else begin
                        iack_o  <= 1'b1;
                        idata_o <= mem_data_i;
                    end
                    r_lastGrant <= r_grant;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_arbiter
// Self-checking bench for memory_arbiter with a behavioural memory and a
// reference array (modelMem) holding the expected memory contents.
// ----------------------------------------------------------------------------
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ireq = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iack;
    logic [31:0] idata;
    logic        dreq = 1'b0;
    logic        dwe = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic        dack;
    logic [31:0] drdata;
    logic        memCs;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memDataOut;
    logic [31:0] memRdata;

    logic        seedEn = 1'b0;
    logic [7:0]  seedAddr = '0;
    logic [31:0] seedData = '0;
    logic [31:0] memArr [0:255];
    logic [31:0] modelMem [0:255];

    logic [31:0] expDrdata;
    logic        monitorOn = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ireq_i     (ireq),
        .iaddr_i    (iaddr),
        .iack_o     (iack),
        .idata_o    (idata),
        .dreq_i     (dreq),
        .dwe_i      (dwe),
        .daddr_i    (daddr),
        .dwdata_i   (dwdata),
        .dack_o     (dack),
        .drdata_o   (drdata),
        .mem_cs_o   (memCs),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_data_o (memDataOut),
        .mem_data_i (memRdata)
    );

    // Single-port memory: samples at the rising edge, read data holds until
    // the next selected access. The seed port preloads words while idle.
    always @(posedge clk) begin
        if (seedEn) begin
            memArr[seedAddr] <= seedData;
        end else if (memCs) begin
            if (memWe) memArr[memAddr[7:0]] <= memDataOut;
            else       memRdata <= memArr[memAddr[7:0]];
        end
    end

    // Acks must never overlap.
    always @(posedge clk) begin
        #1;
        if (monitorOn) begin
            checks++;
            if (iack && dack) begin
                failures++;
                $display("[TB] FAIL ack_exclusive: iack=%0b dack=%0b required not both 1", iack, dack);
            end
        end
    end

    task automatic seedWord(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        seedAddr = a;
        seedData = d;
        seedEn   = 1'b1;
        modelMem[a] = d;
        @(negedge clk);
        seedEn = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst  = 1'b0;
        ireq = 1'b0;
        dreq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expDrdata = '0;
    endtask

    // Drives one request, holds it until its ack, returns edges-to-ack.
    task automatic runAccess(input bit isData, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, output int lat, output logic [31:0] rd);
        @(negedge clk);
        if (isData) begin
            dreq = 1'b1; dwe = we; daddr = addr; dwdata = wd;
        end else begin
            ireq = 1'b1; iaddr = addr;
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(isData ? dack : iack) && lat < 12);
        rd = isData ? drdata : idata;
        if (isData) dreq = 1'b0;
        else        ireq = 1'b0;
    endtask

    task automatic test_reset();
        logic sawAck;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({memCs, memWe, memAddr, memDataOut, iack, dack, idata, drdata} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_initial: outputs=%h required 0",
                     {memCs, memWe, memAddr, memDataOut, iack, dack, idata, drdata});
        end
        @(negedge clk);
        rst = 1'b1;
        ireq = 1'b1;
        iaddr = 32'h1;
        @(posedge clk);
        #1;
        checks++;
        if (memCs !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_pre_cs: got %0b required 1", memCs);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({memCs, memWe, memAddr, memDataOut, iack, dack, idata, drdata} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_access: outputs=%h required 0",
                     {memCs, memWe, memAddr, memDataOut, iack, dack, idata, drdata});
        end
        ireq = 1'b0;
        sawAck = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (iack) sawAck = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (iack || memCs) sawAck = 1'b1;
        end
        checks++;
        if (sawAck) begin
            failures++;
            $display("[TB] FAIL reset_no_ack: activity seen=%0b required 0", sawAck);
        end
        expDrdata = '0;
    endtask

    task automatic test_lone_read();
        seedWord(8'h01, 32'h12345678);
        @(negedge clk);
        ireq = 1'b1;
        iaddr = 32'h1;
        @(posedge clk);
        #1;
        checks++;
        if ({memCs, memWe, memAddr} !== {1'b1, 1'b0, 32'h1}) begin
            failures++;
            $display("[TB] FAIL lone_issue: cs/we/addr=%0b/%0b/%h required 1/0/1", memCs, memWe, memAddr);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({memCs, iack} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL lone_access: cs/iack=%0b/%0b required 0/0", memCs, iack);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({iack, dack, idata} !== {1'b1, 1'b0, 32'h12345678}) begin
            failures++;
            $display("[TB] FAIL lone_ack: iack/dack/idata=%0b/%0b/%h required 1/0/12345678", iack, dack, idata);
        end
        ireq = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (iack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lone_ack_width: iack=%0b required 0", iack);
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [31:0] rd;
        runAccess(1'b1, 1'b1, 32'h0A, 32'd42, lat, rd);
        modelMem[8'h0A] = 32'd42;
        checks++;
        if (lat != 3 || rd !== expDrdata) begin
            failures++;
            $display("[TB] FAIL write_ack: lat=%0d drdata=%h required 3/%h", lat, rd, expDrdata);
        end
        checks++;
        if (memArr[8'h0A] !== 32'd42) begin
            failures++;
            $display("[TB] FAIL write_commit: mem=%h required 2a", memArr[8'h0A]);
        end
        runAccess(1'b1, 1'b0, 32'h0A, 32'h0, lat, rd);
        expDrdata = modelMem[8'h0A];
        checks++;
        if (lat != 3 || rd !== expDrdata) begin
            failures++;
            $display("[TB] FAIL read_back: lat=%0d drdata=%h required 3/%h", lat, rd, expDrdata);
        end
    endtask

    task automatic test_contention();
        int nAck = 0;
        int edges = 0;
        int lastEdge = 0;
        doReset();
        seedWord(8'h02, 32'hCAFE0002);
        @(negedge clk);
        ireq = 1'b1; iaddr = 32'h2;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h0A;
        while (nAck < 4 && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
            if (iack || dack) begin
                checks++;
                if (dack !== nAck[0]) begin
                    failures++;
                    $display("[TB] FAIL contention_order: ack %0d went to dack=%0b required %0b", nAck, dack, nAck[0]);
                end
                checks++;
                if (iack ? (idata !== modelMem[8'h02]) : (drdata !== modelMem[8'h0A])) begin
                    failures++;
                    $display("[TB] FAIL contention_data: idata=%h drdata=%h required %h/%h",
                             idata, drdata, modelMem[8'h02], modelMem[8'h0A]);
                end
                checks++;
                if (edges - lastEdge != 3) begin
                    failures++;
                    $display("[TB] FAIL contention_spacing: ack %0d gap=%0d required 3", nAck, edges - lastEdge);
                end
                lastEdge = edges;
                nAck++;
            end
        end
        ireq = 1'b0;
        dreq = 1'b0;
        expDrdata = modelMem[8'h0A];
        checks++;
        if (nAck != 4) begin
            failures++;
            $display("[TB] FAIL contention_count: acks=%0d required 4", nAck);
        end
    endtask

    task automatic test_early_drop();
        logic [31:0] v;
        int dackCount = 0;
        int csCount = 0;
        v = $urandom;
        @(negedge clk);
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h20; dwdata = v;
        @(posedge clk);
        #1;
        dreq = 1'b0;
        if (memCs) csCount++;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (memCs) csCount++;
            if (dack) begin
                dackCount++;
                checks++;
                if (drdata !== expDrdata) begin
                    failures++;
                    $display("[TB] FAIL drop_drdata: got %h required %h", drdata, expDrdata);
                end
            end
        end
        modelMem[8'h20] = v;
        checks++;
        if (dackCount != 1 || csCount != 1) begin
            failures++;
            $display("[TB] FAIL drop_pulses: dack=%0d cs=%0d required 1/1", dackCount, csCount);
        end
        checks++;
        if (memArr[8'h20] !== modelMem[8'h20]) begin
            failures++;
            $display("[TB] FAIL drop_commit: mem=%h required %h", memArr[8'h20], modelMem[8'h20]);
        end
    endtask

    task automatic test_back_to_back();
        int nAck = 0;
        int edges = 0;
        int lastEdge = 0;
        for (int k = 0; k < 3; k++) seedWord(k[7:0], $urandom);
        @(negedge clk);
        ireq = 1'b1;
        iaddr = 32'h0;
        while (nAck < 3 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (iack) begin
                checks++;
                if (idata !== modelMem[nAck] || edges - lastEdge != 3) begin
                    failures++;
                    $display("[TB] FAIL b2b_ack%0d: idata=%h gap=%0d required %h/3",
                             nAck, idata, edges - lastEdge, modelMem[nAck]);
                end
                lastEdge = edges;
                nAck++;
                iaddr = nAck;
            end
        end
        ireq = 1'b0;
        checks++;
        if (nAck != 3) begin
            failures++;
            $display("[TB] FAIL b2b_count: acks=%0d required 3", nAck);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int a = 0; a < 64; a++) seedWord(a[7:0], $urandom);
        for (int a = 128; a < 192; a++) seedWord(a[7:0], $urandom);
        fork
            begin
                int lat;
                logic [31:0] rd;
                logic [7:0] a;
                for (int n = 0; n < 20; n++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    a = 8'($urandom_range(0, 63));
                    runAccess(1'b0, 1'b0, {24'h0, a}, 32'h0, lat, rd);
                    checks++;
                    if (rd !== modelMem[a] || lat < 3 || lat > 6) begin
                        failures++;
                        $display("[TB] FAIL rand_instr: addr=%h idata=%h lat=%0d required %h lat 3..6",
                                 a, rd, lat, modelMem[a]);
                    end
                end
            end
            begin
                int lat;
                logic [31:0] rd;
                logic [31:0] wd;
                logic [7:0] a;
                bit we;
                for (int n = 0; n < 20; n++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    a  = 8'($urandom_range(128, 191));
                    we = 1'($urandom_range(0, 1));
                    wd = $urandom;
                    runAccess(1'b1, we, {24'h0, a}, wd, lat, rd);
                    if (we) modelMem[a] = wd;
                    else    expDrdata = modelMem[a];
                    checks++;
                    if (rd !== expDrdata || lat < 3 || lat > 6) begin
                        failures++;
                        $display("[TB] FAIL rand_data: addr=%h we=%0b drdata=%h lat=%0d required %h lat 3..6",
                                 a, we, rd, lat, expDrdata);
                    end
                end
            end
        join
        checks++;
        for (int a = 128; a < 192; a++) begin
            if (memArr[a] !== modelMem[a]) begin
                failures++;
                $display("[TB] FAIL rand_memory: addr=%h mem=%h required %h", a, memArr[a], modelMem[a]);
                break;
            end
        end
    endtask

    // Scenarios run in order; contention and random phases reset the DUT
    // so the round-robin pointer starts from a known value.
    initial begin
        expDrdata = '0;
        test_reset();
        monitorOn = 1'b1;
        test_lone_read();
        test_write_read();
        test_contention();
        test_early_drop();
        test_back_to_back();
        test_random();
        monitorOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
